fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: instruction-memory byte address, equal to pc.
REQ-006 The block SHALL have port imem_ready, input, 1 bit: memory has valid data on imem_rdata this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word from memory.
REQ-008 The block SHALL have port instr, output, 32 bits: the registered instruction.
REQ-009 The block SHALL have port op, output, 6 bits: instr[31:26], the opcode feeding the main control decoder.
REQ-010 The block SHALL have port instr_valid, output, 1 bit: instr, op, pc and pc_plus4 are valid for execution.
REQ-011 The block SHALL have port exec_done, input, 1 bit: the datapath has completed the issued instruction; the branch inputs are valid.
REQ-012 The block SHALL have ports br_eq, br_neq, jump and zero, input, 1 bit each: decoder BrEq/BrNeq/Jump strobes and the ALU zero flag.
REQ-013 The block SHALL have port pc, output, 32 bits: address of the current instruction.
REQ-014 The block SHALL have port pc_plus4, output, 32 bits: pc+4, combinational from pc.

Function
REQ-015 The block SHALL implement a three-state FSM with states IDLE, FETCH and ISSUE.
REQ-016 In IDLE the block SHALL unconditionally go to FETCH on the next edge, with imem_req=0 and instr_valid=0.
REQ-017 In FETCH the block SHALL hold imem_req=1 and a stable imem_addr=pc until imem_ready is sampled high.
REQ-018 When imem_ready is sampled high in FETCH, the block SHALL capture imem_rdata into instr and enter ISSUE on that edge.
REQ-019 The block SHALL assert instr_valid throughout ISSUE, starting the cycle after imem_ready (1-cycle fetch-to-issue latency), and SHALL hold instr stable.
REQ-020 The block SHALL ignore imem_ready outside FETCH, and SHALL ignore exec_done, br_eq, br_neq, jump and zero outside ISSUE.
REQ-021 When exec_done is sampled high in ISSUE, the block SHALL load pc with next_pc and enter FETCH on that edge, so imem_req is high with the new address in the next cycle.
REQ-022 next_pc SHALL be {pc_plus4[31:28], instr[25:0], 2'b00} when jump=1.
REQ-023 Otherwise, next_pc SHALL be pc_plus4 + (sign-extended instr[15:0] << 2) when (br_eq & zero) | (br_neq & ~zero).
REQ-024 Otherwise, next_pc SHALL be pc_plus4.
REQ-025 When jump is asserted together with either branch strobe, jump SHALL take priority.
REQ-026 All PC arithmetic SHALL be 32-bit modulo 2^32; pc=32'hFFFF_FFFC SHALL yield pc_plus4=32'h0000_0000.
REQ-027 Branch targets SHALL use two's-complement offsets, so a negative offset wraps below 0 modulo 2^32.
REQ-028 pc[1:0] SHALL always be 2'b00.
REQ-029 exec_done and imem_ready asserted in the same cycle SHALL act only per the current state (REQ-020).

Reset
REQ-030 While rst=1, the block SHALL immediately (asynchronously) force state=IDLE, pc=RESET_PC, instr=0, imem_req=0 and instr_valid=0.
REQ-031 Reset asserted mid-FETCH or mid-ISSUE SHALL abandon the request or instruction with no PC update; a late imem_ready SHALL be ignored.
REQ-032 After rst deasserts, the block SHALL spend one cycle in IDLE, then request RESET_PC.

Verification
REQ-033 The bench SHALL cover reset release with RESET_PC=0, imem_ready after 2 wait cycles and rdata=32'h8C22_0004 -> imem_addr=0, then instr_valid with op=6'b100011; on exec_done, pc=4.
REQ-034 The bench SHALL cover pc=32'h0000_0010 with instr=32'h1000_FFFC, br_eq=1, zero=1 -> pc=32'h0000_0004; the same with zero=0 -> pc=32'h0000_0014.
REQ-035 The bench SHALL cover pc=32'h0000_0020 with instr=32'h1800_0003, br_neq=1, zero=0 -> pc=32'h0000_0030.
REQ-036 The bench SHALL cover pc=32'h1000_0008 with instr=32'h0800_0040, jump=1, br_eq=1, zero=1 -> pc=32'h1000_0100 (jump priority).
REQ-037 The bench SHALL cover pc=32'hFFFF_FFFC with a plain R-format instruction and exec_done -> pc=0; exec_done pulsed during FETCH -> no pc change.
REQ-038 The bench SHALL cover rst pulsed during a FETCH wait, followed by imem_ready after release -> state IDLE, pc=RESET_PC, instr_valid=0, no capture, then a new request to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: three-state instruction fetch FSM (IDLE/FETCH/ISSUE) with
// PC sequencing for jump, BrEq/BrNeq branches and fall-through.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        br_eq,
    input  logic        br_neq,
    input  logic        jump,
    input  logic        zero,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, instr_q, instr_d, next_pc, br_off;
    logic        taken;
    always_comb begin
        taken   = (br_eq & zero) | (br_neq & ~zero);
        br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        next_pc = jump  ? {pc_plus4[31:28], instr_q[25:0], 2'b00} :
                  taken ? pc_plus4 + br_off : pc_plus4;
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE:  state_d = FETCH;
            FETCH: if (imem_ready) begin
                state_d = ISSUE;
                instr_d = imem_rdata;
            end
            ISSUE: if (exec_done) begin
                state_d = FETCH;
                pc_d    = next_pc;
            end
            default: state_d = IDLE;
        endcase
    end
    // low PC bits forced to zero so word alignment holds even for an odd RESET_PC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= {RESET_PC[31:2], 2'b00};
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end
    assign imem_req    = state_q == FETCH;
    assign instr_valid = state_q == ISSUE;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
endmodule
